// File: rtl/cdb_broadcaster_pkg.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster_pkg
//   Shared types and sizing for the common data bus (CDB) transmit side.
//   Contents:
//     NUM_SRC      number of completing sources (ALU, MULT, LD, spare)
//     QUEUE_DEPTH  entries per source queue (power of two, >= 2)
//     TAG_W        width of a physical destination tag
//     SRC_W        width of a source index
//     tag_t        broadcast tag: .tag, .ready, .valid
//     cdb_src_e    symbolic source indices
//     rr_index()   round-robin helper: (ptr + k) modulo NUM_SRC
// -----------------------------------------------------------------------------
package cdb_broadcaster_pkg;

    localparam int NUM_SRC     = 4;
    localparam int QUEUE_DEPTH = 2;
    localparam int TAG_W       = 6;
    localparam int SRC_W       = $clog2(NUM_SRC);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ready;
        logic             valid;
    } tag_t;

    typedef enum logic [SRC_W-1:0] {
        CDB_SRC_ALU   = 2'd0,
        CDB_SRC_MULT  = 2'd1,
        CDB_SRC_LD    = 2'd2,
        CDB_SRC_SPARE = 2'd3
    } cdb_src_e;

    // Source index k positions after ptr, wrapping modulo NUM_SRC.
    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] ptr,
                                                  input int k);
        return SRC_W'((int'(ptr) + k) % NUM_SRC);
    endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster_if
//   Bundles the FU completion side and the CDB broadcast side.
//   Handshake: a source i is accepted at a rising clock edge when
//   fu_done[i]=1 and fu_stall[i]=0 in the cycle before that edge; when
//   fu_stall[i]=1 the request is ignored and the FU must keep presenting it.
//   The CDB side has no back-pressure: listeners qualify on cdb.ready.
//   Signals:
//     squash      master->slave  clear all pending tags
//     fu_done     master->slave  per-source completion request
//     fu_tag      master->slave  per-source tag (.ready/.valid ignored)
//     fu_stall    slave->master  per-source queue full
//     cdb         slave->master  registered broadcast
//     cdb_src     slave->master  source index of the broadcast
//     dbg_rr_ptr  slave->master  round-robin pointer (last winner)
// -----------------------------------------------------------------------------
interface cdb_broadcaster_if;
    import cdb_broadcaster_pkg::*;

    logic                     squash;
    logic [NUM_SRC-1:0]       fu_done;
    tag_t [NUM_SRC-1:0]       fu_tag;
    logic [NUM_SRC-1:0]       fu_stall;
    tag_t                     cdb;
    logic [SRC_W-1:0]         cdb_src;
    logic [SRC_W-1:0]         dbg_rr_ptr;

    modport master (
        output squash, fu_done, fu_tag,
        input  fu_stall, cdb, cdb_src, dbg_rr_ptr
    );

    modport slave (
        input  squash, fu_done, fu_tag,
        output fu_stall, cdb, cdb_src, dbg_rr_ptr
    );

endinterface

// File: rtl/cdb_broadcaster_src_queue.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster_src_queue
//   Small per-source FIFO of completion tags.
//   Ports:
//     clock, reset  clock and asynchronous active-high reset
//     squash        empties the queue; a push in the same cycle is dropped
//     push, push_data  write request (ignored while full)
//     pop           remove head (ignored while empty)
//     head          oldest entry
//     empty, full   registered occupancy flags
//   Pointers wrap naturally because DEPTH is a power of two; the count
//   is one bit wider than the index so "full" is distinguishable.
// -----------------------------------------------------------------------------
module cdb_broadcaster_src_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         squash,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0]   count_q,  count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (IDX_W+1)'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !squash;
    assign pop_ok  = pop && !empty && !squash;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (squash) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + IDX_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + IDX_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (IDX_W+1)'(1);
                2'b01:   count_d = count_q - (IDX_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
//   Transmit side of the common data bus. Buffers completion tags per
//   source, picks one source per cycle round-robin and drives a
//   registered broadcast to every CDB listener (rs, map table, ROB).
//   Ports:
//     clock, reset  clock and asynchronous active-high reset
//     bus           cdb_broadcaster_if.slave (squash, fu_done, fu_tag,
//                   fu_stall, cdb, cdb_src, dbg_rr_ptr)
//   Configuration:
//     CDB_BYPASS_EN  when defined, a request hitting an empty queue may
//                    win arbitration directly and reach cdb at the same
//                    edge without being written into the queue.
// -----------------------------------------------------------------------------
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    cdb_broadcaster_if.slave  bus
);

    logic [TAG_W-1:0]   q_head [NUM_SRC];
    logic [NUM_SRC-1:0] q_empty, q_full;
    logic [NUM_SRC-1:0] q_push, q_pop;
    logic [NUM_SRC-1:0] byp_cand, cand;

    tag_t               cdb_q,     cdb_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
    logic [SRC_W-1:0]   rr_ptr_q,  rr_ptr_d;

    logic               found;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   idx;
    logic [TAG_W-1:0]   win_tag;
    logic               unused_fu_flags;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_queue
        cdb_broadcaster_src_queue #(
            .DEPTH (QUEUE_DEPTH),
            .W     (TAG_W)
        ) u_queue (
            .clock     (clock),
            .reset     (reset),
            .squash    (bus.squash),
            .push      (q_push[g]),
            .push_data (bus.fu_tag[g].tag),
            .pop       (q_pop[g]),
            .head      (q_head[g]),
            .empty     (q_empty[g]),
            .full      (q_full[g])
        );
    end

    // Stall comes from registered occupancy only; a pop in the same cycle
    // does not release it.
    assign bus.fu_stall   = q_full;
    assign bus.cdb        = cdb_q;
    assign bus.cdb_src    = cdb_src_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;

`ifdef CDB_BYPASS_EN
    // An empty queue can never be full, so no stall gating is needed here.
    assign byp_cand = bus.fu_done & q_empty;
`else
    assign byp_cand = '0;
`endif

    assign cand = ~q_empty | byp_cand;

    // Round-robin: first candidate after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = rr_index(rr_ptr_q, k);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A winner with an empty queue can only be a bypass candidate.
    assign win_tag = q_empty[winner] ? bus.fu_tag[winner].tag : q_head[winner];

    always_comb begin
        q_push = bus.fu_done;
        q_pop  = '0;
        if (found) begin
            if (q_empty[winner]) begin
                q_push[winner] = 1'b0;
            end else begin
                q_pop[winner] = 1'b1;
            end
        end
    end

    always_comb begin
        cdb_d     = '0;
        cdb_src_d = cdb_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (!bus.squash && found) begin
            cdb_d.tag   = win_tag;
            cdb_d.ready = 1'b1;
            cdb_d.valid = 1'b1;
            cdb_src_d   = winner;
            rr_ptr_d    = winner;
        end
    end

    // Incoming ready/valid flags carry no meaning for the broadcaster.
    always_comb begin
        unused_fu_flags = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            unused_fu_flags = unused_fu_flags ^ bus.fu_tag[i].ready ^ bus.fu_tag[i].valid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_q     <= '0;
            cdb_src_q <= '0;
            rr_ptr_q  <= SRC_W'(NUM_SRC - 1);
        end else begin
            cdb_q     <= cdb_d;
            cdb_src_q <= cdb_src_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule
